// File: rtl/guvm_wb_arbiter.sv
// rtl/guvm_wb_arbiter.sv - two-master round-robin Wishbone arbiter with per-transfer ack watchdog
module guvm_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,

    input  logic [31:0]  i_m0_wb_adr,
    input  logic [15:0]  i_m0_wb_sel,
    input  logic         i_m0_wb_we,
    input  logic [127:0] i_m0_wb_dat,
    input  logic         i_m0_wb_cyc,
    input  logic         i_m0_wb_stb,
    output logic [127:0] o_m0_wb_dat,
    output logic         o_m0_wb_ack,
    output logic         o_m0_wb_err,

    input  logic [31:0]  i_m1_wb_adr,
    input  logic [15:0]  i_m1_wb_sel,
    input  logic         i_m1_wb_we,
    input  logic [127:0] i_m1_wb_dat,
    input  logic         i_m1_wb_cyc,
    input  logic         i_m1_wb_stb,
    output logic [127:0] o_m1_wb_dat,
    output logic         o_m1_wb_ack,
    output logic         o_m1_wb_err,

    output logic [31:0]  o_wb_adr,
    output logic [15:0]  o_wb_sel,
    output logic         o_wb_we,
    output logic [127:0] o_wb_dat,
    output logic         o_wb_cyc,
    output logic         o_wb_stb,
    input  logic [127:0] i_wb_dat,
    input  logic         i_wb_ack,
    input  logic         i_wb_err,

    output logic [1:0]   o_grant,
    output logic         o_timeout
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam bit WD_ENABLED = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_OWN        = 2'd1,
        S_ABORT_ERR  = 2'd2,
        S_ABORT_WAIT = 2'd3
    } state_t;

    state_t          state;
    logic            own;
    logic            last;
    logic [WD_W-1:0] wd;

    logic [31:0]     own_adr;
    logic [15:0]     own_sel;
    logic            own_we;
    logic [127:0]    own_dat;
    logic            own_cyc;
    logic            own_stb;
    logic            slv_rsp;
    logic            expire;
    logic            winner;
    logic            in_own;
    logic            in_abort_err;

    always_comb begin
        own_adr = own ? i_m1_wb_adr : i_m0_wb_adr;
        own_sel = own ? i_m1_wb_sel : i_m0_wb_sel;
        own_we  = own ? i_m1_wb_we  : i_m0_wb_we;
        own_dat = own ? i_m1_wb_dat : i_m0_wb_dat;
        own_cyc = own ? i_m1_wb_cyc : i_m0_wb_cyc;
        own_stb = own ? i_m1_wb_stb : i_m0_wb_stb;
    end

    assign slv_rsp = i_wb_ack | i_wb_err;
    // An ack/err arriving on the last allowed cycle still completes the transfer.
    assign expire  = WD_ENABLED && own_stb && !slv_rsp && (wd == WD_LAST);
    // On a tie the master that did not win last time takes the bus.
    assign winner  = (i_m0_wb_cyc & i_m1_wb_cyc) ? ~last : i_m1_wb_cyc;

    assign in_own       = (state == S_OWN);
    assign in_abort_err = (state == S_ABORT_ERR);

    always_comb begin
        o_wb_adr    = in_own ? own_adr : 32'd0;
        o_wb_sel    = in_own ? own_sel : 16'd0;
        o_wb_we     = in_own & own_we;
        o_wb_dat    = in_own ? own_dat : 128'd0;
        o_wb_cyc    = in_own & own_cyc;
        o_wb_stb    = in_own & own_stb;

        o_m0_wb_ack = in_own & ~own & i_wb_ack;
        o_m1_wb_ack = in_own &  own & i_wb_ack;
        o_m0_wb_err = ((in_own & i_wb_err) | in_abort_err) & ~own;
        o_m1_wb_err = ((in_own & i_wb_err) | in_abort_err) &  own;

        o_m0_wb_dat = (state == S_IDLE) ? 128'd0 : i_wb_dat;
        o_m1_wb_dat = (state == S_IDLE) ? 128'd0 : i_wb_dat;

        o_grant     = (state == S_IDLE) ? 2'b00 : {own, ~own};
        o_timeout   = in_abort_err;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            own   <= 1'b0;
            last  <= 1'b1;
            wd    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    wd <= '0;
                    if (i_m0_wb_cyc | i_m1_wb_cyc) begin
                        own   <= winner;
                        last  <= winner;
                        state <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (!own_stb || slv_rsp) begin
                        wd <= '0;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                    // A cyc drop takes priority over a simultaneous watchdog expiry.
                    if (!own_cyc) begin
                        state <= S_IDLE;
                    end else if (expire) begin
                        state <= S_ABORT_ERR;
                    end
                end
                S_ABORT_ERR: begin
                    wd    <= '0;
                    state <= own_cyc ? S_ABORT_WAIT : S_IDLE;
                end
                S_ABORT_WAIT: begin
                    wd <= '0;
                    if (!own_cyc) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    wd    <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
